// File: rtl/imager_emulator.sv
// Stonyman imager + 8-bit serial ADC stand-in: decodes the pointer/value pins into the
// sensor register file and answers cs_n/sclk frames on sdata with a synthetic pixel.
module imager_emulator #(
  parameter int         LEAD_ZEROS  = 3,
  parameter int         FRAME_SCLKS = 16,
  parameter int         PATTERN     = 0,
  parameter logic [7:0] CONST_PIXEL = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        cs_n,
  output logic        sdata,
  input  logic        resp,
  input  logic        incp,
  input  logic        resv,
  input  logic        incv,
  input  logic        inphi,
  output logic [2:0]  reg_ptr,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_sel,
  output logic [15:0] inphi_count,
  output logic        frame_error
);

  localparam int NW = $clog2(FRAME_SCLKS + LEAD_ZEROS + 10);
  localparam logic [NW-1:0] FRAME_N = NW'(FRAME_SCLKS);
  localparam logic [NW-1:0] LZ_N    = NW'(LEAD_ZEROS);
  localparam logic [NW-1:0] LZ_END  = NW'(LEAD_ZEROS + 8);

  // Pin order: {inphi, incv, resv, incp, resp, cs_n, sclk}; sclk and cs_n idle high.
  localparam logic [6:0] IDLE_LVL = 7'b0000011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } adc_state_t;

  logic [6:0]  pins_raw;
  logic [6:0]  sync_q, sync_d;
  logic [6:0]  prev_q, prev_d;

  logic        sclk_fall, cs_fall, cs_rise;
  logic        resp_rise, incp_rise, resv_rise, incv_rise, inphi_rise;

  logic [2:0]  ptr_q, ptr_d;
  logic [7:0]  regs_q [8];
  logic [7:0]  regs_d [8];
  logic [15:0] inphi_cnt_q, inphi_cnt_d;

  adc_state_t  state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        sdata_q, sdata_d;
  logic        ferr_q, ferr_d;
  logic [7:0]  pixel;

  assign pins_raw = {inphi, incv, resv, incp, resp, cs_n, sclk};

  always_comb begin
    sync_d = pins_raw;
    prev_d = sync_q;
  end

  assign sclk_fall  =  prev_q[0] & ~sync_q[0];
  assign cs_fall    =  prev_q[1] & ~sync_q[1];
  assign cs_rise    = ~prev_q[1] &  sync_q[1];
  assign resp_rise  = ~prev_q[2] &  sync_q[2];
  assign incp_rise  = ~prev_q[3] &  sync_q[3];
  assign resv_rise  = ~prev_q[4] &  sync_q[4];
  assign incv_rise  = ~prev_q[5] &  sync_q[5];
  assign inphi_rise = ~prev_q[6] &  sync_q[6];

  // Value ops address the pointer as it stood before this cycle's pointer op.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
      if (ptr_q == 3'(i)) begin
        if (resv_rise) begin
          regs_d[i] = 8'd0;
        end else if (incv_rise) begin
          if (i < 4) regs_d[i] = regs_q[i] + 8'd1;
          else       regs_d[i] = {2'b00, regs_q[i][5:0] + 6'd1};
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (resp_rise)      ptr_d = 3'd0;
    else if (incp_rise) ptr_d = ptr_q + 3'd1;
  end

  always_comb begin
    inphi_cnt_d = inphi_cnt_q;
    if (inphi_rise && (inphi_cnt_q != 16'hFFFF)) inphi_cnt_d = inphi_cnt_q + 16'd1;
  end

  always_comb begin
    pixel = regs_q[1] + regs_q[0];
    if (PATTERN == 1)      pixel = CONST_PIXEL;
    else if (PATTERN == 2) pixel = {regs_q[1][3:0], regs_q[0][3:0]};
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    sdata_d = sdata_q;
    ferr_d  = ferr_q;
    case (state_q)
      ST_IDLE: begin
        sdata_d = 1'b0;
        if (cs_fall) begin
          shreg_d = pixel;
          n_d     = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          if (n_q < FRAME_N) ferr_d = 1'b1;
          sdata_d = 1'b0;
          state_d = ST_IDLE;
        end else if (sclk_fall) begin
          n_d = n_q + 1'b1;
          // The shift register is consumed MSB first only inside the data window.
          if ((n_d >= LZ_N) && (n_d < LZ_END)) begin
            sdata_d = shreg_q[7];
            shreg_d = {shreg_q[6:0], 1'b0};
          end else begin
            sdata_d = 1'b0;
          end
          if (n_d == FRAME_N) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        sdata_d = 1'b0;
        if (cs_rise) state_d = ST_IDLE;
      end
      default: begin
        sdata_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= IDLE_LVL;
      prev_q      <= IDLE_LVL;
      ptr_q       <= 3'd0;
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'd0;
      inphi_cnt_q <= 16'd0;
      state_q     <= ST_IDLE;
      n_q         <= '0;
      shreg_q     <= 8'd0;
      sdata_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      ptr_q       <= ptr_d;
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
      inphi_cnt_q <= inphi_cnt_d;
      state_q     <= state_d;
      n_q         <= n_d;
      shreg_q     <= shreg_d;
      sdata_q     <= sdata_d;
      ferr_q      <= ferr_d;
    end
  end

  assign sdata       = sdata_q;
  assign reg_ptr     = ptr_q;
  assign row_sel     = regs_q[1];
  assign col_sel     = regs_q[0];
  assign inphi_count = inphi_cnt_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_imager_emulator.sv
// Bench for imager_emulator: three instances (one per pixel pattern) share the pins; a
// register/ADC model tracks expected state and a compare process checks every settled cycle.
module tb_imager_emulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, sclk, cs_n, resp, incp, resv, incv, inphi;

  logic        sdata0, sdata1, sdata2;
  logic [2:0]  ptr0, ptr1, ptr2;
  logic [7:0]  row0, row1, row2, col0, col1, col2;
  logic [15:0] inphi0, inphi1, inphi2;
  logic        ferr0, ferr1, ferr2;

  imager_emulator #(.LEAD_ZEROS(3), .FRAME_SCLKS(16), .PATTERN(0), .CONST_PIXEL(8'hA5)) dut0 (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .sdata(sdata0),
    .resp(resp), .incp(incp), .resv(resv), .incv(incv), .inphi(inphi),
    .reg_ptr(ptr0), .row_sel(row0), .col_sel(col0), .inphi_count(inphi0), .frame_error(ferr0));

  imager_emulator #(.LEAD_ZEROS(3), .FRAME_SCLKS(16), .PATTERN(1), .CONST_PIXEL(8'hA5)) dut1 (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .sdata(sdata1),
    .resp(resp), .incp(incp), .resv(resv), .incv(incv), .inphi(inphi),
    .reg_ptr(ptr1), .row_sel(row1), .col_sel(col1), .inphi_count(inphi1), .frame_error(ferr1));

  imager_emulator #(.LEAD_ZEROS(3), .FRAME_SCLKS(16), .PATTERN(2), .CONST_PIXEL(8'hA5)) dut2 (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .sdata(sdata2),
    .resp(resp), .incp(incp), .resv(resv), .incv(incv), .inphi(inphi),
    .reg_ptr(ptr2), .row_sel(row2), .col_sel(col2), .inphi_count(inphi2), .frame_error(ferr2));

  localparam logic [4:0] RESP  = 5'b00001;
  localparam logic [4:0] INCP  = 5'b00010;
  localparam logic [4:0] RESV  = 5'b00100;
  localparam logic [4:0] INCV  = 5'b01000;
  localparam logic [4:0] INPHI = 5'b10000;

  int n_checks = 0;
  int n_fail   = 0;
  bit settled  = 1'b0;

  int m_ptr;
  int m_reg [8];
  int m_inphi;
  int m_ferr;

  logic [15:0] s0, s1, s2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    m_inphi = 0;
    m_ferr  = 0;
  endtask

  task automatic model_apply(input logic [4:0] m);
    int old;
    old = m_ptr;
    if (m[2])      m_reg[old] = 0;
    else if (m[3]) m_reg[old] = (m_reg[old] + 1) % ((old < 4) ? 256 : 64);
    if (m[0])      m_ptr = 0;
    else if (m[1]) m_ptr = (m_ptr + 1) % 8;
    if (m[4] && m_inphi < 65535) m_inphi++;
  endtask

  task automatic pins(input logic [4:0] m, input int count);
    for (int c = 0; c < count; c++) begin
      settled = 1'b0;
      resp = m[0]; incp = m[1]; resv = m[2]; incv = m[3]; inphi = m[4];
      tick(2);
      resp = 1'b0; incp = 1'b0; resv = 1'b0; incv = 1'b0; inphi = 1'b0;
      tick(2);
      model_apply(m);
      settled = 1'b1;
    end
    $display("pins op=%05b x%0d -> ptr=%0d col=%0d row=%0d", m, count, m_ptr, m_reg[0], m_reg[1]);
  endtask

  function automatic int exp_bit(input int pix, input int k);
    if (k >= 3 && k < 11) return (pix >> (10 - k)) & 1;
    return 0;
  endfunction

  // One ADC frame; sdata is sampled just before each sclk fall, as a capture controller would.
  task automatic frame(input int nfalls, input bit bump_mid);
    int p0, p1, p2;
    settled = 1'b0;
    s0 = '0; s1 = '0; s2 = '0;
    p0 = (m_reg[1] + m_reg[0]) % 256;
    p1 = 'hA5;
    p2 = (m_reg[1] % 16) * 16 + (m_reg[0] % 16);
    cs_n = 1'b0;
    tick(3);
    for (int k = 0; k < nfalls; k++) begin
      if (bump_mid && k == 5) begin
        incv = 1'b1; tick(2); incv = 1'b0; tick(2);
        model_apply(INCV);
      end
      check("sdata_p0", sdata0, exp_bit(p0, k));
      check("sdata_p1", sdata1, exp_bit(p1, k));
      check("sdata_p2", sdata2, exp_bit(p2, k));
      s0 = {s0[14:0], sdata0};
      s1 = {s1[14:0], sdata1};
      s2 = {s2[14:0], sdata2};
      sclk = 1'b0; tick(2); sclk = 1'b1; tick(2);
    end
    if (nfalls == 16) begin
      check("sdata_done", {sdata2, sdata1, sdata0}, 0);
      sclk = 1'b0; tick(2); sclk = 1'b1; tick(2);
      check("sdata_done_extra_sclk", {sdata2, sdata1, sdata0}, 0);
    end
    cs_n = 1'b1;
    tick(4);
    if (nfalls < 16) m_ferr = 1;
    $display("frame falls=%0d pix=%02h/%02h/%02h stream=%04h/%04h/%04h", nfalls, p0, p1, p2, s0, s1, s2);
    settled = 1'b1;
  endtask

  always @(posedge clk) begin
    #2;
    if (settled) begin
      check("reg_ptr", ptr0, m_ptr);
      check("col_sel", col0, m_reg[0]);
      check("row_sel", row0, m_reg[1]);
      check("inphi_count", inphi0, m_inphi);
      check("frame_error_p0", ferr0, m_ferr);
      check("frame_error_p1", ferr1, m_ferr);
      check("frame_error_p2", ferr2, m_ferr);
      check("sdata_idle", {sdata2, sdata1, sdata0}, 0);
    end
  end

  initial begin
    reset = 1'b0;
    sclk = 1'b1; cs_n = 1'b1;
    resp = 1'b0; incp = 1'b0; resv = 1'b0; incv = 1'b0; inphi = 1'b0;
    model_reset();
    tick(3);
    check("reset_reg_ptr", ptr0, 0);
    check("reset_row_sel", row0, 0);
    check("reset_col_sel", col0, 0);
    check("reset_inphi", inphi0, 0);
    check("reset_frame_error", ferr0, 0);
    check("reset_sdata", {sdata2, sdata1, sdata0}, 0);
    reset = 1'b1;
    tick(2);
    settled = 1'b1;

    // Pointer and value ops
    pins(RESP, 1); pins(INCP, 1); pins(RESV, 1); pins(INCV, 37);
    check("row_sel_37", row0, 37);
    check("reg_ptr_1", ptr0, 1);
    pins(INCP, 7);
    check("reg_ptr_wrap", ptr0, 0);

    // Field-width wraps
    pins(INCP, 4); pins(RESV, 1); pins(INCV, 64);
    check("model_vref_wrap", m_reg[4], 0);
    pins(RESP, 1); pins(INCP, 2); pins(INCV, 256);
    check("model_vsw_wrap", m_reg[2], 0);
    pins(RESP, 1); pins(INCV, 255);
    check("col_sel_255", col0, 255);
    pins(INCV, 1);
    check("col_sel_wrap", col0, 0);
    pins(INPHI, 5);
    check("inphi_5", inphi0, 5);

    // row=3, col=5 frame
    pins(RESP, 1); pins(INCP, 1); pins(RESV, 1); pins(INCV, 3);
    pins(RESP, 1); pins(RESV, 1); pins(INCV, 5);
    frame(16, 1'b0);
    check("stream_p0_0x08", s0, 16'h0100);
    check("stream_p1_0xA5", s1, 16'h14A0);
    check("stream_p2_0x35", s2, 16'h06A0);

    // COLSEL bumped mid-frame: frame data stays, next frame sees col=6
    frame(16, 1'b1);
    check("stream_p0_stable", s0, 16'h0100);
    check("stream_p1_stable", s1, 16'h14A0);
    check("col_sel_6", col0, 6);
    frame(16, 1'b0);
    check("stream_p0_0x09", s0, 16'h0120);
    check("stream_p2_0x36", s2, 16'h06C0);

    // Short frame
    frame(9, 1'b0);
    check("frame_error_set", ferr0, 1);
    frame(16, 1'b0);
    check("stream_after_error", s0, 16'h0120);
    check("frame_error_sticky", ferr0, 1);

    // Simultaneous edges
    pins(INCP, 3);
    pins(RESP | INCP, 1);
    check("resp_over_incp", ptr0, 0);
    pins(INCP | INCV, 1);
    check("incv_old_ptr_col", col0, 7);
    check("incp_with_incv", ptr0, 1);
    pins(RESV | INCV, 1);
    check("resv_over_incv", row0, 0);

    // Reset mid-frame
    settled = 1'b0;
    cs_n = 1'b0;
    tick(3);
    for (int k = 0; k < 3; k++) begin
      sclk = 1'b0; tick(2); sclk = 1'b1; tick(2);
    end
    check("sdata_p1_pre_reset", sdata1, 1);
    #2;
    reset = 1'b0;
    cs_n = 1'b1;
    #1;
    check("sdata_async_reset", {sdata2, sdata1, sdata0}, 0);
    check("col_sel_async_reset", col0, 0);
    check("frame_error_async_reset", ferr0, 0);
    model_reset();
    tick(2);
    reset = 1'b1;
    tick(2);
    settled = 1'b1;
    frame(16, 1'b0);
    check("stream_p0_after_reset", s0, 16'h0000);
    check("stream_p1_after_reset", s1, 16'h14A0);

    settled = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
